// File: rtl/ebr_block_reader.sv
// ebr_block_reader: streams one 8x8 block out of an EBR line buffer.
// Credit-limited issue keeps the 4-entry output FIFO from overflowing.
module ebr_block_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int ROW_STRIDE = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [5:0]            idx;
  logic [5:0]            nidx;
  logic                  v1, v2, l1, l2;

  logic [DATA_WIDTH-1:0] fdata [4];
  logic [3:0]            flast;
  logic [1:0]            wptr, rptr;
  logic [2:0]            count;

  logic [2:0] inflight;
  logic       credit;
  logic       push, pop;
  logic       drain_done;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(
    input logic [ADDR_WIDTH-1:0] b,
    input logic [5:0]            i
  );
    logic [31:0] s;
    s = 32'(b) + 32'(i[5:3]) * 32'(ROW_STRIDE) + 32'(i[2:0]);
    return s[ADDR_WIDTH-1:0];
  endfunction

  assign inflight   = {2'b0, v1} + {2'b0, v2};
  assign credit     = (count + inflight) < 3'd4;
  assign nidx       = idx + 6'd1;
  assign push       = v2;
  assign pop        = dout_valid && dout_ready;
  assign drain_done = !v1 && !v2 && (count == 3'd1) && pop;

  assign busy       = (state != S_IDLE);
  assign dout_valid = (count != 3'd0);
  assign dout       = fdata[rptr];
  assign dout_last  = flast[rptr] && dout_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      base_q <= '0;
      raddr  <= '0;
      idx    <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      l1     <= 1'b0;
      l2     <= 1'b0;
    end else begin
      v2 <= v1;
      l2 <= l1;
      case (state)
        S_IDLE: begin
          v1 <= 1'b0;
          if (start) begin
            base_q <= base_addr;
            raddr  <= base_addr;
            idx    <= '0;
            v1     <= 1'b1;
            l1     <= 1'b0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Without credit raddr holds; the EBR re-read is simply dropped.
          if (credit) begin
            idx   <= nidx;
            raddr <= addr_of(base_q, nidx);
            v1    <= 1'b1;
            l1    <= (nidx == 6'd63);
            if (nidx == 6'd63)
              state <= S_DRAIN;
          end else begin
            v1 <= 1'b0;
          end
        end
        S_DRAIN: begin
          v1 <= 1'b0;
          if (drain_done)
            state <= S_IDLE;
        end
        default: begin
          v1    <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++)
        fdata[k] <= '0;
      flast <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fdata[wptr] <= rdata;
        flast[wptr] <= l2;
        wptr        <= wptr + 2'd1;
      end
      if (pop)
        rptr <= rptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};
    end
  end

endmodule
